fp_r4_wb_buffer: RTL
====================

// Module: fp_r4_wb_buffer
// PURPOSE
//   Writeback buffer directly downstream of the fused multiply-add (R4) unit.
//   Captures each completed R4 result with its destination tag and exception flags.
//   Presents results to the FP register-file writeback arbiter over a valid/ready handshake.
//   Back-pressures the R4 pipeline enable when it cannot accept a result.
// PARAMETERS
//   ADDR_W  5  register-address width of rd
//   DEPTH   2  number of buffer entries; power of two, >= 2
// PORTS
//   clk              in   1          core clock; all state on posedge
//   rst              in   1          asynchronous, active-high reset
//   in_valid         in   1          R4 result valid (R4 p_out_signal)
//   in_result        in   32         R4 result, IEEE-754 single
//   in_rd            in   ADDR_W     destination register
//   in_fp_reg_write  in   1          FP register-file write enable for this result
//   in_flags         in   5          exception flags {NV,DZ,OF,UF,NX}
//   flush            in   1          synchronous pipeline flush
//   stall_o          out  1          drives R4 en low; the R4 unit holds its output while set
//   out_valid        out  1          head entry valid
//   out_ready        in   1          arbiter accepts head this cycle
//   out_result       out  32         head result
//   out_rd           out  ADDR_W     head rd
//   out_fp_reg_write out  1          head FP write enable
//   out_flags        out  5          head flags
//   pend_valid_o     out  DEPTH      per-entry occupancy, for hazard/forwarding logic
//   pend_rd_o        out  DEPTH*ADDR_W  per-entry rd; entry i at [i*ADDR_W +: ADDR_W]
//   fflags_o         out  5          sticky accumulated flags; see CONFIGURATION
//   fflags_clr       in   1          clear sticky flags; see CONFIGURATION
// BEHAVIOUR
//   - Circular FIFO.
//     - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
//     - count ranges 0..DEPTH.
//   - push = in_valid && !flush && (count<DEPTH || pop).
//     - Writes entry[wr_ptr]; wr_ptr+1.
//   - pop = out_valid && out_ready && !flush.
//     - rd_ptr+1.
//   - Push and pop in the same cycle: count unchanged, including when full.
//   - stall_o = (count==DEPTH) && !out_ready, combinational.
//     - in_valid while stall_o is set is not consumed.
//     - The R4 unit re-presents the same result next cycle.
//   - Latency:
//     - push at cycle N gives out_valid at N+1.
//     - No combinational input-to-output bypass.
//   - out_* reflect entry[rd_ptr]; out_valid = (count!=0).
//     - When count==0, out_result, out_rd, out_fp_reg_write and out_flags are 0.
//   - Entries are queued regardless of in_fp_reg_write or rd value; rd=0 is not filtered.
//   - pend_valid_o[i] = 1 iff entry i currently holds a live result.
//   - flush has priority over push and pop:
//     - next cycle count=0, pointers=0, all pend_valid_o=0.
//     - The same-cycle in_valid is dropped.
//   - Reset: all pointers, count and entries are 0.
//     - All outputs are 0 during and after reset, including stall_o and fflags_o.
//     - Reset mid-operation discards all buffered results.
//   - Full with no pop: storage is never overwritten; stall_o is asserted.
// CONFIGURATION
//   FP_WB_FFLAGS_ACCUM_EN defined:
//     - fflags_o is a sticky 5-bit register; on pop, fflags_o |= out_flags.
//     - fflags_clr clears it next cycle.
//     - fflags_clr with a simultaneous pop: the result equals the popped entry's flags.
//     - flush does not affect fflags_o.
//   FP_WB_FFLAGS_ACCUM_EN undefined:
//     - fflags_o is tied to 0 and fflags_clr is ignored.
//     - Ports are present in both builds.
// TESTING
//   1. Single push of 0x40490FDB, rd=7, out_ready=1:
//      out_valid=1 with those values on the next cycle only; count returns to 0.
//   2. out_ready=0, push 3 results (DEPTH=2):
//      stall_o=1 after the 2nd push; the 3rd result is held; release drains FIFO order A,B,C.
//   3. Full with out_ready=1 and in_valid=1 every cycle:
//      push+pop each cycle; stall_o=0; count stays 2; no loss across 8 pointer wraps.
//   4. flush with count=2 and concurrent in_valid:
//      next cycle out_valid=0, pend_valid_o=0; the flush-cycle input is dropped.
//   5. rst pulse asserted asynchronously mid-drain:
//      all outputs 0 immediately; stale entries never reappear after release.
//   6. FP_WB_FFLAGS_ACCUM_EN defined: pop flags 5'b00001 then 5'b10000 gives fflags_o=5'b10001;
//      fflags_clr with a pop of 5'b00100 gives 5'b00100.
//      Undefined: fflags_o stays 0.

Source files
------------

// File: rtl/fp_r4_wb_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_r4_wb_buffer_if
// Description : Bus bundle between the R4 (FMA) unit / writeback arbiter side
//               (master) and the R4 writeback buffer (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface fp_r4_wb_buffer_if #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
);
   // R4 result side
   logic                     in_valid;
   logic [31:0]              in_result;
   logic [ADDR_W-1:0]        in_rd;
   logic                     in_fp_reg_write;
   logic [4:0]               in_flags;
   logic                     flush;
   logic                     stall_o;
   // writeback arbiter side
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_result;
   logic [ADDR_W-1:0]        out_rd;
   logic                     out_fp_reg_write;
   logic [4:0]               out_flags;
   // hazard / status side
   logic [DEPTH-1:0]         pend_valid_o;
   logic [DEPTH*ADDR_W-1:0]  pend_rd_o;
   logic [4:0]               fflags_o;
   logic                     fflags_clr;

   modport master (
      output in_valid, in_result, in_rd, in_fp_reg_write, in_flags, flush,
             out_ready, fflags_clr,
      input  stall_o, out_valid, out_result, out_rd, out_fp_reg_write,
             out_flags, pend_valid_o, pend_rd_o, fflags_o
   );

   modport slave (
      input  in_valid, in_result, in_rd, in_fp_reg_write, in_flags, flush,
             out_ready, fflags_clr,
      output stall_o, out_valid, out_result, out_rd, out_fp_reg_write,
             out_flags, pend_valid_o, pend_rd_o, fflags_o
   );
endinterface
`default_nettype wire

// File: rtl/fp_r4_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fp_r4_wb_buffer
// Description : Circular writeback FIFO between the R4 fused multiply-add unit
//               and the FP register-file writeback arbiter. Stalls R4 when full
//               and not draining; exposes per-entry occupancy/rd for hazards.
//               Optional feature macro: FP_WB_FFLAGS_ACCUM_EN (sticky fflags).
// Revision    : 1.0  initial release
// ============================================================================
module fp_r4_wb_buffer #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2
) (
   input  wire                     clk,
   input  wire                     rst,
   fp_r4_wb_buffer_if.slave        bus
);

   localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_FULL    = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [31:0]       r_result [DEPTH];
   logic [ADDR_W-1:0] r_rd     [DEPTH];
   logic              r_we     [DEPTH];
   logic [4:0]        r_flags  [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_push;
   logic w_pop;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_FULL);
   // A pop frees a slot in the same cycle, so a full buffer still accepts a
   // result when the arbiter is draining the head.
   assign w_pop   = !w_empty && bus.out_ready && !bus.flush;
   assign w_push  = bus.in_valid && !bus.flush && (!w_full || w_pop);

   assign bus.stall_o   = w_full && !bus.out_ready;
   assign bus.out_valid = !w_empty;

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (bus.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_CNT_ONE;
            2'b01:   r_count <= r_count - C_CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; written only on an accepted push, so a full buffer is
   // never overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_result[i] <= '0;
            r_rd[i]     <= '0;
            r_we[i]     <= 1'b0;
            r_flags[i]  <= '0;
         end
      end else if (w_push) begin
         r_result[r_wr_ptr] <= bus.in_result;
         r_rd[r_wr_ptr]     <= bus.in_rd;
         r_we[r_wr_ptr]     <= bus.in_fp_reg_write;
         r_flags[r_wr_ptr]  <= bus.in_flags;
      end
   end

   // Head presentation; payload forced to zero while the buffer is empty.
   always_comb begin
      bus.out_result       = '0;
      bus.out_rd           = '0;
      bus.out_fp_reg_write = 1'b0;
      bus.out_flags        = '0;
      if (!w_empty) begin
         bus.out_result       = r_result[r_rd_ptr];
         bus.out_rd           = r_rd[r_rd_ptr];
         bus.out_fp_reg_write = r_we[r_rd_ptr];
         bus.out_flags        = r_flags[r_rd_ptr];
      end
   end

   // Entry i is live when its distance from the head is below the occupancy.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_pend
         logic [PTR_W-1:0] w_off;
         logic             w_live;
         assign w_off  = PTR_W'(gi) - r_rd_ptr;
         assign w_live = ({1'b0, w_off} < r_count);
         assign bus.pend_valid_o[gi] = w_live;
         assign bus.pend_rd_o[gi*ADDR_W +: ADDR_W] = w_live ? r_rd[gi] : '0;
      end
   endgenerate

`ifdef FP_WB_FFLAGS_ACCUM_EN
   logic [4:0] r_fflags;
   logic [4:0] w_pop_flags;

   assign w_pop_flags = w_pop ? bus.out_flags : 5'b0;

   // Sticky flag accumulator; a clear still keeps the flags popped this cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fflags <= '0;
      end else if (bus.fflags_clr) begin
         r_fflags <= w_pop_flags;
      end else begin
         r_fflags <= r_fflags | w_pop_flags;
      end
   end

   assign bus.fflags_o = r_fflags;
`else
   logic w_unused_fflags_clr;

   assign w_unused_fflags_clr = bus.fflags_clr;
   assign bus.fflags_o        = 5'b0;
`endif

endmodule
`default_nettype wire
